// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared core-wide widths and constants for the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;
  localparam int WORDSIZE   = 64;
  localparam int INSTRSIZE  = 32;
  localparam int INSTR_STEP = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Instruction-memory req/ack bus plus decode valid/ready bus.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
  parameter int WORDSIZE  = riscv_pkg::WORDSIZE,
  parameter int INSTRSIZE = riscv_pkg::INSTRSIZE
);
  logic                 mem_req;
  logic [WORDSIZE-1:0]  mem_addr;
  logic                 mem_ack;
  logic [INSTRSIZE-1:0] mem_rdata;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTRSIZE-1:0] instr;
  logic [WORDSIZE-1:0]  instr_addr;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_addr,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_addr,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Small registered FIFO with flush and a registered head output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW-1:0]  r_wptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_do_pop;
  logic [c_AW-1:0]  w_rptr_next;
  logic [c_CW-1:0]  w_count_next;

  assign w_do_pop     = pop && (r_count != '0);
  assign w_rptr_next  = r_rptr + c_AW'(w_do_pop);
  assign w_count_next = r_count + c_CW'(push) - c_CW'(w_do_pop);

  // Head is registered so it keeps its last value once the queue drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + c_AW'(1);
      end
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      if (w_count_next != '0) begin
        r_head <= (push && (r_wptr == w_rptr_next)) ? push_data : r_mem[w_rptr_next];
      end
    end
  end

  assign full  = (r_count == c_CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_head;
endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : One-at-a-time instruction fetch with a small return queue.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int WORDSIZE  = riscv_pkg::WORDSIZE,
  parameter int INSTRSIZE = riscv_pkg::INSTRSIZE,
  parameter int QDEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] pc_addr,
  output logic                pc_hold,
  input  logic                redirect,
  instruction_fetch_if.master bus
);
  localparam int c_CW = $clog2(QDEPTH) + 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_FETCH   = 2'd1;
  localparam logic [1:0] c_DISCARD = 2'd2;

  logic [1:0]                    r_state;
  logic [WORDSIZE-1:0]           r_mem_addr;
  logic [c_CW-1:0]               w_count;
  logic [c_CW-1:0]               w_count_next;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_ack_ok;
  logic                          w_pop;
  logic [WORDSIZE+INSTRSIZE-1:0] w_head;

  assign w_ack_ok = (r_state == c_FETCH) && bus.mem_ack && !redirect;
  assign pc_hold  = !(w_ack_ok && !reset);
  assign w_pop    = !w_empty && bus.instr_ready;

  // A pop in the same cycle frees a slot, keeping zero-wait fetch at 1/cycle.
  assign w_count_next = w_count + c_CW'(1) - c_CW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!redirect && !w_full) begin
            r_state    <= c_FETCH;
            r_mem_addr <= pc_addr;
          end
        end
        c_FETCH: begin
          if (redirect) begin
            r_state <= bus.mem_ack ? c_IDLE : c_DISCARD;
          end else if (bus.mem_ack) begin
            if (w_count_next < c_CW'(QDEPTH)) begin
              r_mem_addr <= pc_addr + WORDSIZE'(INSTR_STEP);
            end else begin
              r_state <= c_IDLE;
            end
          end
        end
        c_DISCARD: begin
          // The request already on the bus must complete; its data is dropped.
          if (bus.mem_ack) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (WORDSIZE + INSTRSIZE)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (w_ack_ok),
    .push_data ({r_mem_addr, bus.mem_rdata}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign bus.mem_req     = (r_state == c_FETCH) || (r_state == c_DISCARD);
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = !w_empty;
  assign bus.instr_addr  = w_head[WORDSIZE+INSTRSIZE-1:INSTRSIZE];
  assign bus.instr       = w_head[INSTRSIZE-1:0];
endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Downstream neighbour of program_counter.
- Takes the PC address, issues one instruction-memory read at a time with a req/ack handshake, and buffers returned instructions with their addresses in a small queue.
- Presents instructions to decode with a valid/ready handshake.
- Drives pc_hold so the PC advances only when its current address has been consumed.

Parameters:
- WORDSIZE, 64, address width (matches program_counter addr)
- INSTRSIZE, 32, instruction width
- QDEPTH, 2, fetch queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_addr  in  WORDSIZE  current PC value from program_counter
- pc_hold  out  1  1 = PC must not advance this edge
- redirect  in  1  branch/jump taken; flush all fetched and in-flight work
- mem_req  out  1  read request to instruction memory
- mem_addr  out  WORDSIZE  read address, stable while mem_req=1
- mem_ack  in  1  memory accepts request; mem_rdata valid in the same cycle
- mem_rdata  in  INSTRSIZE  instruction word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr  out  INSTRSIZE  queue head instruction
- instr_addr  out  WORDSIZE  address of queue head

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE, queue count=0, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_addr=0.
  - pc_hold=1 while reset is high.
  - Reset overrides every other input, including mid-request: the outstanding request is abandoned and the memory side is required to tolerate a dropped req.
- FSM states:
  - IDLE: mem_req=0. Next edge -> FETCH when count<QDEPTH and redirect=0. mem_addr<=pc_addr on that transition.
  - FETCH: mem_req=1, mem_addr held.
    - On mem_ack=1 with redirect=0: push {mem_addr, mem_rdata}. Consume: pc_hold=0 this cycle (combinational) so the PC advances at this edge.
    - After the push, if count_after_push<QDEPTH, stay in FETCH and load mem_addr<=pc_addr+4, giving back-to-back fetches at 1/cycle with a zero-wait memory. Otherwise go to IDLE.
    - Note: pc_addr+4 equals the PC value after the advance; the PC steps by 4.
  - DISCARD: entered from FETCH when redirect=1 and mem_ack=0. mem_req stays 1 with the old mem_addr (a request is never retracted). On mem_ack the data is dropped -> IDLE. pc_hold=1 throughout.
- pc_hold = NOT(state==FETCH AND mem_ack AND NOT redirect AND NOT reset). It is 1 in every other case.
- Redirect:
  - Clears the queue (count<=0, instr_valid<=0) at that edge.
  - Has priority over a simultaneous pop and a simultaneous ack: the acked data is dropped, state goes to IDLE, pc_hold=1.
  - In IDLE it only flushes.
  - The new target is read from pc_addr on the next IDLE->FETCH transition.
- Queue:
  - Registered FIFO with read pointer, write pointer and count; pointers wrap modulo QDEPTH.
  - Pop on instr_valid AND instr_ready. Push and pop in the same cycle leave count unchanged.
  - Push never happens when full, because a request is issued only with count<QDEPTH and only this block pushes.
  - instr_valid = count!=0 (registered). Latency from mem_ack edge to instr_valid=1 is 1 cycle.
  - instr and instr_addr show the head entry. They hold their last value when empty; when empty after reset they read 0.
- Widths: address arithmetic is modulo 2^WORDSIZE (0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0). No misalignment checks.

Decomposition:
- Shared package riscv_pkg: WORDSIZE, INSTRSIZE, INSTR_STEP=4, NOP=32'h0000_0013.
- Fetch FSM state encoding (IDLE/FETCH/DISCARD) lives locally.
- One sub-module: fetch_queue (parameterised FIFO: push, pop, flush, full, empty, head data). The FSM and handshake logic stay in instruction_fetch.

Test Plan:
- Reset then zero-wait memory (mem_ack tied 1, rdata=addr[31:0]), instr_ready=1, PC from 0 -> instr_addr sequence 0,4,8,C on consecutive cycles, with instr equal to the address. pc_hold=0 every fetch cycle.
- instr_ready=0, zero-wait memory -> exactly 2 entries (addr 0,4) queued. mem_req drops to 0 and pc_hold=1 while full. Raising instr_ready resumes at addr 8 with no lost or duplicated entry.
- mem_ack delayed 3 cycles for addr 0x10 -> mem_req and mem_addr=0x10 stable for all 3 cycles, pc_hold=1. On the ack cycle pc_hold=0. instr_valid rises the next cycle with instr_addr=0x10.
- Redirect asserted while a request to 0x20 is pending (no ack), PC forced to 0x100 -> state DISCARD. The ack 2 cycles later drops the data with no instr_valid. The next fetch uses mem_addr=0x100. The queue is empty immediately after redirect.
- Redirect in the same cycle as mem_ack and a pop with 1 entry queued -> queue empty, acked data not pushed, pc_hold=1.
- Reset asserted mid-FETCH with 2 entries queued -> next cycle mem_req=0, instr_valid=0, instr=0, instr_addr=0, pc_hold=1 while reset is high.
